// File: rtl/kid_motion_if.sv
// kid_motion_if: bundles the per-frame control inputs and the kid state outputs.
//   tick        - one-cycle frame update strobe
//   keys        - [0]=left [1]=right [2]=jump [3]=respawn, active-high levels
//   is_collide  - [0]=top blocked [1]=floor under feet [2]=left blocked [3]=right blocked
//   direction   - 1=facing right, 0=facing left
//   action      - 00 idle, 01 run, 10 jump (rising), 11 fall
//   pos_x/pos_y - sprite top-left corner
// master: the game/frame logic side. slave: the kid_motion block.
interface kid_motion_if;
  logic       tick;
  logic [3:0] keys;
  logic [3:0] is_collide;
  logic       direction;
  logic [1:0] action;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  modport master (
    output tick, keys, is_collide,
    input  direction, action, pos_x, pos_y
  );

  modport slave (
    input  tick, keys, is_collide,
    output direction, action, pos_x, pos_y
  );
endinterface

// File: rtl/kid_motion.sv
// kid_motion: per-frame kid state (position, facing, action) from keys and
// collision flags. Walking, variable-height jump, one mid-air double jump,
// gravity with terminal velocity, respawn. State advances only on tick.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   bus  - kid_motion_if.slave (tick, keys, is_collide in; direction,
//          action, pos_x, pos_y out, all registered)
module kid_motion #(
  parameter int SPAWN_X  = 40,
  parameter int SPAWN_Y  = 400,
  parameter int SPEED    = 3,
  parameter int JUMP_V   = 8,
  parameter int DJUMP_V  = 7,
  parameter int MAX_FALL = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int KID_W    = 31,
  parameter int KID_H    = 23
) (
  input  logic        clk,
  input  logic        rst,
  kid_motion_if.slave bus
);
  // action output is the state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_JUMP = 2'b10;
  localparam logic [1:0] ST_FALL = 2'b11;

  localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - KID_W);
  localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - KID_H);
  localparam logic signed [10:0] STEP     = 11'(SPEED);
  localparam logic signed [5:0]  VY_JUMP  = 6'(-JUMP_V);
  localparam logic signed [5:0]  VY_DJUMP = 6'(-DJUMP_V);
  localparam logic signed [5:0]  VY_MAXF  = 6'(MAX_FALL);
  localparam logic signed [5:0]  VY_ONE   = 6'sd1;
  localparam logic signed [5:0]  VY_NEG1  = -6'sd1;
  localparam logic [9:0]         SPAWN_X10 = 10'(SPAWN_X);
  localparam logic [9:0]         SPAWN_Y10 = 10'(SPAWN_Y);

  logic [1:0]        state_q, state_d;
  logic signed [5:0] vy_q, vy_d;
  logic              djump_q, djump_d;
  logic              jump_prev_q, jump_prev_d;
  logic              dir_q, dir_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;

  logic              k_left, k_right, k_jump, k_respawn;
  logic              c_top, c_floor, c_left, c_right;
  logic              jump_edge, jump_rel;
  logic [1:0]        walk_state;
  logic signed [5:0] vy_mag;
  logic signed [10:0] x_sum, y_sum;
  logic              vy_pos, vy_neg;

  assign {k_respawn, k_jump, k_right, k_left} = bus.keys;
  assign {c_right, c_left, c_floor, c_top}    = bus.is_collide;
  assign jump_edge  = k_jump & ~jump_prev_q;
  assign jump_rel   = ~k_jump & jump_prev_q;
  assign walk_state = (k_left ^ k_right) ? ST_RUN : ST_IDLE;

  always_comb begin
    state_d     = state_q;
    vy_d        = vy_q;
    djump_d     = djump_q;
    jump_prev_d = jump_prev_q;
    dir_d       = dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vy_mag      = '0;
    x_sum       = $signed({1'b0, pos_x_q});
    y_sum       = $signed({1'b0, pos_y_q});
    vy_pos      = 1'b0;
    vy_neg      = 1'b0;

    if (bus.tick) begin
      jump_prev_d = k_jump;
      if (k_respawn) begin
        state_d = ST_IDLE;
        vy_d    = '0;
        djump_d = 1'b0;
        dir_d   = 1'b1;
        pos_x_d = SPAWN_X10;
        pos_y_d = SPAWN_Y10;
      end else begin
        // horizontal
        if (k_left && !k_right) begin
          dir_d = 1'b0;
          if (!c_left) x_sum = x_sum - STEP;
        end else if (k_right && !k_left) begin
          dir_d = 1'b1;
          if (!c_right) x_sum = x_sum + STEP;
        end
        if (x_sum[10])         pos_x_d = '0;
        else if (x_sum > X_MAX) pos_x_d = X_MAX[9:0];
        else                   pos_x_d = x_sum[9:0];

        // vertical state machine
        case (state_q)
          ST_IDLE, ST_RUN: begin
            if (jump_edge) begin
              state_d = ST_JUMP;
              vy_d    = VY_JUMP;
              djump_d = 1'b1;
            end else if (!c_floor) begin
              state_d = ST_FALL;
              vy_d    = VY_ONE;
              djump_d = 1'b1;
            end else begin
              state_d = walk_state;
              vy_d    = '0;
            end
          end
          ST_JUMP: begin
            if (c_top) begin
              state_d = ST_FALL;
              vy_d    = '0;
            end else begin
              if (jump_edge && djump_q) begin
                vy_d    = VY_DJUMP;
                djump_d = 1'b0;
              end else if (jump_rel && (vy_q < VY_NEG1)) begin
                // early release: halve upward speed toward zero, skip gravity
                vy_mag = -vy_q;
                vy_d   = -(vy_mag >>> 1);
              end else begin
                vy_d = vy_q + VY_ONE;
              end
              if (!vy_d[5]) state_d = ST_FALL;
            end
          end
          ST_FALL: begin
            if (c_floor) begin
              state_d = walk_state;
              vy_d    = '0;
            end else if (jump_edge && djump_q) begin
              state_d = ST_JUMP;
              vy_d    = VY_DJUMP;
              djump_d = 1'b0;
            end else if (vy_q >= VY_MAXF) begin
              vy_d = VY_MAXF;
            end else begin
              vy_d = vy_q + VY_ONE;
            end
          end
        endcase

        // vertical position, blocked against the surface being moved into
        vy_pos = !vy_d[5] && (vy_d != '0);
        vy_neg = vy_d[5];
        if (!((vy_pos && c_floor) || (vy_neg && c_top)))
          y_sum = y_sum + {{5{vy_d[5]}}, vy_d};
        if (y_sum[10]) begin
          pos_y_d = '0;
        end else if (y_sum >= Y_MAX) begin
          pos_y_d = Y_MAX[9:0];
          // bottom edge of the playfield acts as a floor
          if (vy_pos) begin
            vy_d    = '0;
            state_d = walk_state;
          end
        end else begin
          pos_y_d = y_sum[9:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      vy_q        <= '0;
      djump_q     <= 1'b0;
      jump_prev_q <= 1'b0;
      dir_q       <= 1'b1;
      pos_x_q     <= SPAWN_X10;
      pos_y_q     <= SPAWN_Y10;
    end else begin
      state_q     <= state_d;
      vy_q        <= vy_d;
      djump_q     <= djump_d;
      jump_prev_q <= jump_prev_d;
      dir_q       <= dir_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign bus.direction = dir_q;
  assign bus.action    = state_q;
  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
endmodule

// File: tb/tb_kid_motion.sv
module tb_kid_motion;
  logic clk;
  logic rst;
  kid_motion_if bif ();

  kid_motion dut (.clk(clk), .rst(rst), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] k;
    logic [3:0] c;
    int         x;
    int         y;
    logic       d;
    logic [1:0] a;
  } vec_t;
  vec_t vecs[$];

  // behavioural reference: plain ints, motion mode + grounded run flag
  typedef enum {M_GROUND, M_RISING, M_FALLING} mode_e;
  int    m_x, m_y, m_vy;
  logic  m_dir, m_dj, m_jp, m_run;
  mode_e m_mode;

  task automatic m_reset();
    m_x = 40; m_y = 400; m_vy = 0; m_dir = 1'b1; m_dj = 1'b0; m_jp = 1'b0;
    m_run = 1'b0; m_mode = M_GROUND;
  endtask

  function automatic logic [1:0] m_act();
    case (m_mode)
      M_GROUND: return m_run ? 2'b01 : 2'b00;
      M_RISING: return 2'b10;
      default:  return 2'b11;
    endcase
  endfunction

  task automatic model_tick(input logic [3:0] k, input logic [3:0] c);
    bit l = k[0], r = k[1], j = k[2];
    bit edg = j && !m_jp;
    bit rel = !j && m_jp;
    bit walk = l ^ r;
    int vy;
    m_jp = j;
    if (k[3]) begin
      m_x = 40; m_y = 400; m_vy = 0; m_dir = 1'b1; m_dj = 1'b0;
      m_run = 1'b0; m_mode = M_GROUND;
      return;
    end
    if (l && !r) begin m_dir = 1'b0; if (!c[2]) m_x = m_x - 3; end
    if (r && !l) begin m_dir = 1'b1; if (!c[3]) m_x = m_x + 3; end
    if (m_x < 0) m_x = 0;
    if (m_x > 640 - 31) m_x = 640 - 31;
    vy = m_vy;
    case (m_mode)
      M_GROUND:
        if (edg) begin m_mode = M_RISING; vy = -8; m_dj = 1'b1; end
        else if (!c[1]) begin m_mode = M_FALLING; vy = 1; m_dj = 1'b1; end
        else begin vy = 0; m_run = walk; end
      M_RISING:
        if (c[0]) begin m_mode = M_FALLING; vy = 0; end
        else begin
          if (edg && m_dj) begin vy = -7; m_dj = 1'b0; end
          else if (rel && vy < -1) vy = -((-vy) / 2);
          else vy = vy + 1;
          if (vy >= 0) m_mode = M_FALLING;
        end
      default:
        if (c[1]) begin m_mode = M_GROUND; vy = 0; m_run = walk; end
        else if (edg && m_dj) begin m_mode = M_RISING; vy = -7; m_dj = 1'b0; end
        else vy = (vy + 1 > 9) ? 9 : vy + 1;
    endcase
    if (!((vy > 0 && c[1]) || (vy < 0 && c[0]))) m_y = m_y + vy;
    if (m_y < 0) m_y = 0;
    if (m_y >= 457) begin
      m_y = 457;
      if (vy > 0) begin vy = 0; m_mode = M_GROUND; m_run = walk; end
    end
    m_vy = vy;
  endtask

  task automatic apply(input logic t, input logic [3:0] k, input logic [3:0] c);
    bif.tick = t; bif.keys = k; bif.is_collide = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int x, input int y,
                       input logic d, input logic [1:0] a);
    checks++;
    if (bif.pos_x !== 10'(x) || bif.pos_y !== 10'(y) ||
        bif.direction !== d || bif.action !== a) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d dir=%0b act=%0b, expected x=%0d y=%0d dir=%0b act=%0b",
               name, bif.pos_x, bif.pos_y, bif.direction, bif.action, x, y, d, a);
    end
  endtask

  task automatic add(input logic [3:0] k, input logic [3:0] c, input int x,
                     input int y, input logic d, input logic [1:0] a);
    vec_t v;
    v.k = k; v.c = c; v.x = x; v.y = y; v.d = d; v.a = a;
    vecs.push_back(v);
  endtask

  initial begin
    // walk
    add(4'b0010, 4'b0010, 43, 400, 1, 2'b01);
    add(4'b0010, 4'b0010, 46, 400, 1, 2'b01);
    add(4'b0010, 4'b0010, 49, 400, 1, 2'b01);
    add(4'b0001, 4'b0010, 46, 400, 0, 2'b01);
    add(4'b0000, 4'b0010, 46, 400, 0, 2'b00);
    // full jump, floor only on the first tick
    add(4'b0100, 4'b0010, 46, 392, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 385, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 379, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 374, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 370, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 367, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 365, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 364, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 364, 0, 2'b11);
    add(4'b0100, 4'b0000, 46, 365, 0, 2'b11);
    add(4'b0100, 4'b0010, 46, 365, 0, 2'b00);
    // variable height
    add(4'b0000, 4'b0010, 46, 365, 0, 2'b00);
    add(4'b0100, 4'b0010, 46, 357, 0, 2'b10);
    add(4'b0100, 4'b0000, 46, 350, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 347, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 345, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 344, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 344, 0, 2'b11);
    // double jump, then a second edge that must not jump
    add(4'b0000, 4'b0000, 46, 345, 0, 2'b11);
    add(4'b0100, 4'b0000, 46, 338, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 335, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 333, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 332, 0, 2'b10);
    add(4'b0000, 4'b0000, 46, 332, 0, 2'b11);
    add(4'b0100, 4'b0000, 46, 333, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 335, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 338, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 342, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 347, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 353, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 360, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 368, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 377, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 386, 0, 2'b11);
    add(4'b0000, 4'b0000, 46, 395, 0, 2'b11);
    add(4'b0000, 4'b0010, 46, 395, 0, 2'b00);
    // right blocked
    add(4'b0010, 4'b1010, 46, 395, 1, 2'b01);
    // top collision beats double-jump edge
    add(4'b0100, 4'b0010, 46, 387, 1, 2'b10);
    add(4'b0000, 4'b0000, 46, 383, 1, 2'b10);
    add(4'b0100, 4'b0001, 46, 383, 1, 2'b11);
    // respawn mid-air
    add(4'b1000, 4'b0000, 40, 400, 1, 2'b00);

    // reset with tick toggling
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(i == 0, 4'b0110, 4'b0000);
      check($sformatf("reset%0d", i), 40, 400, 1, 2'b00);
    end
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b1, vecs[i].k, vecs[i].c);
      check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].a);
    end

    // no tick: hold
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'b0110, 4'b0000);
      check($sformatf("hold%0d", i), 40, 400, 1, 2'b00);
    end

    // free fall onto the bottom edge of the playfield
    for (int i = 0; i < 10; i++) apply(1'b1, 4'b0000, 4'b0000);
    check("fall_454", 40, 454, 1, 2'b11);
    apply(1'b1, 4'b0000, 4'b0000);
    check("bottom_land", 40, 457, 1, 2'b00);

    // left clamp: 1 - 3 -> 0
    for (int i = 0; i < 13; i++) apply(1'b1, 4'b0001, 4'b0010);
    check("left_x1", 1, 457, 0, 2'b01);
    apply(1'b1, 4'b0001, 4'b0010);
    check("left_clamp", 0, 457, 0, 2'b01);

    // right clamp at 609
    for (int i = 0; i < 203; i++) apply(1'b1, 4'b0010, 4'b0010);
    check("right_609", 609, 457, 1, 2'b01);
    apply(1'b1, 4'b0010, 4'b0010);
    check("right_clamp", 609, 457, 1, 2'b01);

    // reset mid-jump without tick
    apply(1'b1, 4'b0100, 4'b0010);
    check("jump_from_bottom", 609, 449, 1, 2'b10);
    rst = 1'b0;
    apply(1'b0, 4'b0100, 4'b0000);
    check("reset_midair", 40, 400, 1, 2'b00);
    rst = 1'b1;
    m_reset();

    // randomized against the reference model
    for (int i = 0; i < 4000; i++) begin
      logic       t;
      logic [2:0] kb;
      logic [3:0] k, c;
      t  = ($urandom_range(0, 3) != 0);
      kb = 3'($urandom_range(0, 7));
      k  = {($urandom_range(0, 49) == 0), kb};
      c  = 4'($urandom_range(0, 15));
      apply(t, k, c);
      if (t) model_tick(k, c);
      check($sformatf("rand%0d", i), m_x, m_y, m_dir, m_act());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kid_motion.md
Name: kid_motion

Overview:
- Produces the kid's per-frame state (position, facing, action) from player keys and four collision flags.
- Drives the kid sprite renderer and the collision detector. Its outputs define the sprite's top-left corner and the animation select.
- Implements walking, a variable-height jump, one mid-air double jump, gravity with terminal velocity, and respawn.
- All state advances only on cycles where tick=1.

Parameters:
SPAWN_X, 40, reset/respawn pos_x
SPAWN_Y, 400, reset/respawn pos_y
SPEED, 3, horizontal pixels per tick
JUMP_V, 8, initial upward speed of ground jump (px/tick)
DJUMP_V, 7, initial upward speed of double jump
MAX_FALL, 9, terminal downward speed
SCREEN_W, 640, playfield width
SCREEN_H, 480, playfield height
KID_W, 31, sprite width
KID_H, 23, sprite height

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (rst=0 resets on clk rising edge)
tick  input  1  one-cycle update strobe (once per frame)
keys  input  4  [0]=left, [1]=right, [2]=jump, [3]=respawn; level-sensitive, active-high
is_collide  input  4  [0]=top blocked, [1]=floor under feet, [2]=left blocked, [3]=right blocked; valid for current pos on tick cycles
direction  output  1  1=facing right, 0=facing left
action  output  2  00 idle, 01 run, 10 jump (rising), 11 fall
pos_x  output  10  sprite left column
pos_y  output  10  sprite top row

Behaviour:
- Reset state: pos_x=SPAWN_X, pos_y=SPAWN_Y, direction=1, action=00, vy=0, djump=0, jump_prev=0.
- All outputs are registered. A tick at cycle N produces its result at cycle N+1.
- Without tick, state and outputs hold, and jump_prev does not update.
- Internal state:
  - vy: signed 6-bit, negative = up.
  - djump: double jump available.
  - jump_prev: keys[2] sampled at the last tick.
  - jump_edge = keys[2] & ~jump_prev.
  - jump_rel = ~keys[2] & jump_prev.
- Per-tick priority 1: keys[3]=1 applies reset values, except jump_prev, which still updates. This overrides everything else.
- Horizontal:
  - Only left pressed: direction=0; pos_x -= SPEED unless is_collide[2].
  - Only right pressed: direction=1; pos_x += SPEED unless is_collide[3].
  - Both or neither: no move, direction unchanged.
  - pos_x is clamped to [0, SCREEN_W-KID_W]. Compute in 11-bit signed, so 1-3 → 0.
- Vertical: vy_new is computed first by the state rules below. Then pos_y_next = pos_y + vy_new.
  - Exception: if vy_new>0 and is_collide[1]=1, pos_y does not move.
  - Exception: if vy_new<0 and is_collide[0]=1, pos_y does not move.
  - pos_y is clamped to [0, SCREEN_H-KID_H=457]. Reaching 457 while falling counts as landing (vy=0, grounded next).
- FSM; action equals the state encoding:
  - IDLE/RUN (grounded):
    - jump_edge → JUMP, vy_new=-JUMP_V, djump=1.
    - Else if is_collide[1]=0 → FALL, vy_new=1, djump=1.
    - Else exactly one of left/right pressed → RUN, otherwise IDLE; vy_new=0.
  - JUMP:
    - is_collide[0]=1 → FALL, vy_new=0.
    - Else jump_edge & djump → stay JUMP, vy_new=-DJUMP_V, djump=0.
    - Else jump_rel & vy<-1 → vy_new=-((-vy)>>1) (halve toward zero, no gravity that tick).
    - Else vy_new=vy+1.
    - If vy_new≥0 → FALL.
  - FALL:
    - is_collide[1]=1 → IDLE/RUN (by keys as above), vy_new=0.
    - Else jump_edge & djump → JUMP, vy_new=-DJUMP_V, djump=0.
    - Else vy_new=min(vy+1, MAX_FALL).
- Simultaneous events:
  - Floor and jump_edge in FALL: landing wins; the jump requires a new edge on a later tick.
  - Top collision and double-jump edge in JUMP: top wins.
  - Horizontal and vertical resolve independently in the same tick.
- Reset mid-jump/mid-air: state returns to reset values at the next clk edge, regardless of tick.

Test Plan:
- Reset: rst=0 for 2 clks, tick toggling → pos=(40,400), direction=1, action=00, outputs stable while rst=0.
- Walk: is_collide=0010, keys=0010, 3 ticks → pos_x 40→49, action=01, direction=1. Then keys=0001, 1 tick → direction=0, pos_x=46. Then keys=0000 → action=00.
- Full jump on floor: keys[2] held from tick1, floor=1 only at tick1.
  - pos_y per tick: 392, 385, 379, 374, 370, 367, 365, 364.
  - Tick9: vy_new=0 → action=11, pos_y=364.
  - Floor asserted later → action=00, vy=0.
- Variable height: release jump after tick2 (pos_y=385, vy=-7) → tick3 vy=-3, pos_y=382; tick6 vy=0 → FALL.
- Double jump: during FALL press jump edge → action=10, pos_y decreases by 7. A second edge later in the air → no new jump, falls with vy capped at 9 px/tick.
- Boundaries:
  - pos_x=2, keys=0001 → pos_x=0.
  - Right held with is_collide[3]=1 → pos_x unchanged, direction=1.
  - keys[3] mid-air → pos=(40,400), action=00 next cycle.
